thre_ram_arbiter: RTL and testbench
===================================

Name: thre_ram_arbiter

Overview:
Sequences and arbitrates the write port of the 64-channel spike-threshold store (two 32-deep banks: channels 0-31 "lo", 32-63 "hi"). There are two requesters: host threshold-download frames and the on-chip auto-calibration engine (sqrt results). The block grants one writer per cycle, keeps host bursts atomic with a bounded fairness slot for calibration, and tracks which channels hold a valid threshold. It sits between the host frame decoder / calibration engine and the threshold RAMs.

Parameters:
FAIR_LIMIT, 8, consecutive host words accepted while calc is pending before one calc slot is forced (1..255)
HOST_TIMEOUT, 1024, idle cycles inside a host burst before the burst is aborted (2..65535)
SWAP_HOST, 1, 1 = byte-swap host data ({d[7:0],d[15:8]}) before writing; 0 = pass through

Ports:
clk_in  in  1  system clock
reset  in  1  asynchronous, active-high reset
h_valid  in  1  host word valid
h_sop  in  1  first word of host threshold frame
h_eop  in  1  last word of host threshold frame
h_addr  in  6  host target channel
h_data  in  16  host threshold word
h_ready  out  1  host word accepted when h_valid&&h_ready
c_valid  in  1  calc result valid
c_addr  in  6  calc target channel
c_data  in  16  calc threshold (written unswapped)
c_ready  out  1  calc word accepted when c_valid&&c_ready
cal_freeze  in  1  blocks all calc acceptance
clr_map  in  1  clears loaded_map
ram_we_lo  out  1  write strobe, bank 0-31
ram_we_hi  out  1  write strobe, bank 32-63
ram_wr_addr  out  5  bank-local address
ram_wr_data  out  16  write data
loaded_map  out  64  bit n = channel n written since last clear
all_loaded  out  1  registered &loaded_map
arb_busy  out  1  high when state != IDLE
frame_cnt  out  16  completed host frames (wraps)
timeout_err  out  1  one-cycle pulse on burst abort

Behaviour:
- Reset: state IDLE; every output 0 (h_ready/c_ready deassert immediately). Any write in flight is dropped.
- States: IDLE, HOST, FAIR, ENDF.
- IDLE:
  - h_ready=1.
  - c_ready = !h_valid && !cal_freeze.
  - h_valid&&h_sop: accept the word; go to HOST, or to ENDF if h_eop is also set.
  - h_valid without h_sop: accept and discard; no write, no state change.
- HOST:
  - h_ready=1, c_ready=0.
  - Each accepted word increments run_cnt; run_cnt clears on entry.
  - h_eop accepted -> ENDF.
  - h_sop accepted mid-burst: write it and continue (new frame, no count).
  - If c_valid && !cal_freeze && run_cnt==FAIR_LIMIT -> FAIR, run_cnt cleared.
  - Idle counter increments on cycles without h_valid and clears on h_valid; at HOST_TIMEOUT -> IDLE with timeout_err pulse, frame_cnt unchanged.
- FAIR: exactly one cycle. h_ready=0; c_ready = !cal_freeze. Next state HOST regardless of c_valid; the idle counter holds.
- ENDF: one cycle. h_ready=0, c_ready=0. frame_cnt+1; next state IDLE.
- Simultaneous requests: host always wins, except in FAIR.
- Write pipeline: a word accepted in cycle N drives ram_we_* high for exactly cycle N+1.
  - ram_we_lo = !addr[5], ram_we_hi = addr[5]; ram_wr_addr = addr[4:0].
  - ram_wr_data = swapped host data or raw calc data.
  - With no accept, both strobes are 0 and addr/data hold their last value.
  - Peak rate: one write per cycle.
- loaded_map: bit set in the write cycle. clr_map clears it; if clr_map coincides with a write, the clear wins except for the bit being written, which stays set. all_loaded follows one cycle later.
- Reset asserted mid-burst: run_cnt, idle counter, map and frame_cnt all return to 0.

Test Plan:
- Host frame of 64 words (sop on ch0, eop on ch63, data 16'h1234+n), SWAP_HOST=1 -> 64 strobes, 32 lo then 32 hi; first data 16'h3412; frame_cnt=1; all_loaded=1 two cycles after the last strobe.
- Calc-only: c_valid with c_addr=37, c_data=16'h00A0 in IDLE -> c_ready=1; next cycle ram_we_hi=1, ram_wr_addr=5, data 16'h00A0; loaded_map[37]=1.
- Host burst with c_valid held high, FAIR_LIMIT=8 -> calc is written after host words 8, 16, ...; h_ready=0 in exactly those FAIR cycles; no word is lost.
- Host stalls after sop with HOST_TIMEOUT=16 -> timeout_err pulses after 16 idle cycles; state IDLE; frame_cnt unchanged; calc is then accepted.
- cal_freeze=1 with c_valid high for 100 cycles -> c_ready never asserts; no calc writes.
- Reset asserted at host word 10 -> all outputs 0 next edge; no strobe for word 10; loaded_map=0.

Source files
------------

// File: rtl/thre_ram_arbiter.sv
`timescale 1ns/1ps
// Arbitrates host threshold frames and calibration results onto the write port
// of the two-bank (lo: ch 0-31, hi: ch 32-63) spike-threshold RAM, tracking loaded channels.
module thre_ram_arbiter #(
   parameter int unsigned FAIR_LIMIT   = 8,
   parameter int unsigned HOST_TIMEOUT = 1024,
   parameter bit          SWAP_HOST    = 1'b1
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        h_valid,
   input  logic        h_sop,
   input  logic        h_eop,
   input  logic [5:0]  h_addr,
   input  logic [15:0] h_data,
   output logic        h_ready,
   input  logic        c_valid,
   input  logic [5:0]  c_addr,
   input  logic [15:0] c_data,
   output logic        c_ready,
   input  logic        cal_freeze,
   input  logic        clr_map,
   output logic        ram_we_lo,
   output logic        ram_we_hi,
   output logic [4:0]  ram_wr_addr,
   output logic [15:0] ram_wr_data,
   output logic [63:0] loaded_map,
   output logic        all_loaded,
   output logic        arb_busy,
   output logic [15:0] frame_cnt,
   output logic        timeout_err
);

   typedef enum logic [1:0] {IDLE, HOST, FAIR, ENDF} state_t;

   localparam logic [7:0]  FairLim    = 8'(FAIR_LIMIT);
   localparam logic [15:0] TimeoutLim = 16'(HOST_TIMEOUT);

   state_t      state_q, state_d;
   logic [7:0]  runCnt_q, runCnt_d, runNext;
   logic [15:0] idleCnt_q, idleCnt_d;
   logic [15:0] frameCnt_q, frameCnt_d;
   logic        timeoutErr_q, timeoutErr_d;
   logic        weLo_q, weLo_d, weHi_q, weHi_d;
   logic [4:0]  wrAddr_q, wrAddr_d;
   logic [15:0] wrData_q, wrData_d;
   logic [63:0] map_q, map_d, writeBit;
   logic        allLoaded_q;
   logic        hReady, cReady, hostWrite;

   // The sop word accepted in IDLE counts as the first word of the fairness window.
   always_comb begin
      state_d      = state_q;
      runCnt_d     = runCnt_q;
      idleCnt_d    = idleCnt_q;
      frameCnt_d   = frameCnt_q;
      timeoutErr_d = 1'b0;
      runNext      = runCnt_q;
      hReady       = 1'b0;
      cReady       = 1'b0;
      hostWrite    = 1'b0;
      case (state_q)
         IDLE: begin
            hReady = 1'b1;
            cReady = !h_valid && !cal_freeze;
            if (h_valid && h_sop) begin
               hostWrite = 1'b1;
               runCnt_d  = 8'd1;
               idleCnt_d = 16'd0;
               state_d   = h_eop ? ENDF : HOST;
            end
         end
         HOST: begin
            hReady    = 1'b1;
            hostWrite = h_valid;
            runNext   = (runCnt_q >= FairLim) ? runCnt_q : runCnt_q + {7'd0, h_valid};
            runCnt_d  = runNext;
            idleCnt_d = h_valid ? 16'd0 : idleCnt_q + 16'd1;
            if (h_valid && h_eop) begin
               state_d = ENDF;
            end else if (!h_valid && (idleCnt_q + 16'd1 == TimeoutLim)) begin
               state_d      = IDLE;
               timeoutErr_d = 1'b1;
            end else if (c_valid && !cal_freeze && (runNext >= FairLim)) begin
               state_d  = FAIR;
               runCnt_d = 8'd0;
            end
         end
         FAIR: begin
            cReady  = !cal_freeze;
            state_d = HOST;
         end
         ENDF: begin
            frameCnt_d = frameCnt_q + 16'd1;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Host and calc acceptance are mutually exclusive, so the mux order is free.
   always_comb begin
      weLo_d   = 1'b0;
      weHi_d   = 1'b0;
      wrAddr_d = wrAddr_q;
      wrData_d = wrData_q;
      if (hostWrite) begin
         weLo_d   = !h_addr[5];
         weHi_d   = h_addr[5];
         wrAddr_d = h_addr[4:0];
         wrData_d = SWAP_HOST ? {h_data[7:0], h_data[15:8]} : h_data;
      end else if (c_valid && cReady) begin
         weLo_d   = !c_addr[5];
         weHi_d   = c_addr[5];
         wrAddr_d = c_addr[4:0];
         wrData_d = c_data;
      end
   end

   always_comb begin
      writeBit = '0;
      if (weLo_q || weHi_q) begin
         writeBit[{weHi_q, wrAddr_q}] = 1'b1;
      end
      map_d = (clr_map ? 64'd0 : map_q) | writeBit;
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         runCnt_q     <= '0;
         idleCnt_q    <= '0;
         frameCnt_q   <= '0;
         timeoutErr_q <= 1'b0;
         weLo_q       <= 1'b0;
         weHi_q       <= 1'b0;
         wrAddr_q     <= '0;
         wrData_q     <= '0;
         map_q        <= '0;
         allLoaded_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         runCnt_q     <= runCnt_d;
         idleCnt_q    <= idleCnt_d;
         frameCnt_q   <= frameCnt_d;
         timeoutErr_q <= timeoutErr_d;
         weLo_q       <= weLo_d;
         weHi_q       <= weHi_d;
         wrAddr_q     <= wrAddr_d;
         wrData_q     <= wrData_d;
         map_q        <= map_d;
         allLoaded_q  <= &map_q;
      end
   end

   // Readies are gated by reset so they drop the instant reset asserts.
   assign h_ready     = hReady && !reset;
   assign c_ready     = cReady && !reset;
   assign ram_we_lo   = weLo_q;
   assign ram_we_hi   = weHi_q;
   assign ram_wr_addr = wrAddr_q;
   assign ram_wr_data = wrData_q;
   assign loaded_map  = map_q;
   assign all_loaded  = allLoaded_q;
   assign arb_busy    = (state_q != IDLE);
   assign frame_cnt   = frameCnt_q;
   assign timeout_err = timeoutErr_q;

endmodule

// File: tb/tb_thre_ram_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for thre_ram_arbiter: randomized host/calc traffic checked
// against a transaction-level model of grants, RAM writes, loaded map and frame count.
module tb_thre_ram_arbiter;

   localparam int FairLimit   = 8;
   localparam int HostTimeout = 16;

   logic        clk_in = 1'b0;
   logic        reset = 1'b1;
   logic        h_valid = 1'b0, h_sop = 1'b0, h_eop = 1'b0;
   logic [5:0]  h_addr = '0;
   logic [15:0] h_data = '0;
   logic        h_ready;
   logic        c_valid = 1'b0;
   logic [5:0]  c_addr = '0;
   logic [15:0] c_data = '0;
   logic        c_ready;
   logic        cal_freeze = 1'b0, clr_map = 1'b0;
   logic        ram_we_lo, ram_we_hi;
   logic [4:0]  ram_wr_addr;
   logic [15:0] ram_wr_data;
   logic [63:0] loaded_map;
   logic        all_loaded, arb_busy, timeout_err;
   logic [15:0] frame_cnt;

   int          vectors = 0;
   int          miscompares = 0;
   logic [63:0] expMap = '0;
   int          expFrames = 0;

   thre_ram_arbiter #(
      .FAIR_LIMIT(FairLimit), .HOST_TIMEOUT(HostTimeout), .SWAP_HOST(1'b1)
   ) dut (
      .clk_in(clk_in), .reset(reset),
      .h_valid(h_valid), .h_sop(h_sop), .h_eop(h_eop), .h_addr(h_addr), .h_data(h_data),
      .h_ready(h_ready),
      .c_valid(c_valid), .c_addr(c_addr), .c_data(c_data), .c_ready(c_ready),
      .cal_freeze(cal_freeze), .clr_map(clr_map),
      .ram_we_lo(ram_we_lo), .ram_we_hi(ram_we_hi), .ram_wr_addr(ram_wr_addr),
      .ram_wr_data(ram_wr_data), .loaded_map(loaded_map), .all_loaded(all_loaded),
      .arb_busy(arb_busy), .frame_cnt(frame_cnt), .timeout_err(timeout_err)
   );

   // Free-running 10 ns clock.
   always #5 clk_in = ~clk_in;

   function automatic logic [22:0] strobeOf(input logic [5:0] a, input logic [15:0] d);
      return {~a[5], a[5], a[4:0], d};
   endfunction

   function automatic logic [15:0] swapB(input logic [15:0] d);
      return {d[7:0], d[15:8]};
   endfunction

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic quiet();
      h_valid = 1'b0; h_sop = 1'b0; h_eop = 1'b0;
      c_valid = 1'b0; clr_map = 1'b0;
   endtask

   // Reset holds every output low even with both requesters valid.
   task automatic test_reset();
      reset = 1'b1; h_valid = 1'b1; c_valid = 1'b1;
      tick(); tick();
      vectors++;
      if ({h_ready, c_ready} !== 2'b00)
         $display("[TB] FAIL reset_ready: got %b want 00", {h_ready, c_ready});
      if ({h_ready, c_ready} !== 2'b00) miscompares++;
      vectors++;
      if ({ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data, loaded_map, all_loaded,
           arb_busy, frame_cnt, timeout_err} !== '0) begin
         miscompares++;
         $display("[TB] FAIL reset_regs: got we=%b%b a=%h d=%h map=%h al=%b busy=%b fc=%0d to=%b want all 0",
                  ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data, loaded_map, all_loaded,
                  arb_busy, frame_cnt, timeout_err);
      end
      quiet();
      reset = 1'b0;
      tick();
      vectors++;
      if ({h_ready, c_ready, arb_busy} !== 3'b110) begin
         miscompares++;
         $display("[TB] FAIL idle_ready: got %b want 110", {h_ready, c_ready, arb_busy});
      end
   endtask

   // Full 64-channel host frame, byte-swapped data, lo bank then hi bank.
   task automatic test_full_frame();
      logic [15:0] d;
      for (int n = 0; n < 64; n++) begin
         d = 16'h1234 + 16'(n);
         h_valid = 1'b1; h_sop = (n == 0); h_eop = (n == 63);
         h_addr = 6'(n); h_data = d;
         #1;
         vectors++;
         if (h_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL frame_h_ready[%0d]: got %b want 1", n, h_ready);
         end
         tick();
         vectors++;
         if ({ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data} !== strobeOf(6'(n), swapB(d))) begin
            miscompares++;
            $display("[TB] FAIL frame_strobe[%0d]: got %h want %h", n,
                     {ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data}, strobeOf(6'(n), swapB(d)));
         end
         expMap[n] = 1'b1;
      end
      quiet();
      #1;
      vectors++;
      if ({h_ready, c_ready, arb_busy} !== 3'b001) begin
         miscompares++;
         $display("[TB] FAIL endf_ready: got %b want 001", {h_ready, c_ready, arb_busy});
      end
      tick();
      expFrames++;
      vectors++;
      if (frame_cnt !== 16'(expFrames)) begin
         miscompares++;
         $display("[TB] FAIL frame_cnt: got %0d want %0d", frame_cnt, expFrames);
      end
      vectors++;
      if ({loaded_map, ram_we_lo, ram_we_hi} !== {expMap, 2'b00}) begin
         miscompares++;
         $display("[TB] FAIL frame_map: got %h we=%b%b want %h we=00", loaded_map,
                  ram_we_lo, ram_we_hi, expMap);
      end
      tick();
      vectors++;
      if (all_loaded !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL all_loaded: got %b want 1", all_loaded);
      end
   endtask

   // Calc writes in IDLE, including a clear that coincides with a write.
   task automatic test_calc_only();
      logic [5:0]  a;
      logic [15:0] d;
      clr_map = 1'b1;
      tick();
      clr_map = 1'b0;
      expMap = '0;
      vectors++;
      if (loaded_map !== 64'd0) begin
         miscompares++;
         $display("[TB] FAIL clr_map: got %h want 0", loaded_map);
      end
      c_valid = 1'b1; c_addr = 6'd37; c_data = 16'h00A0;
      #1;
      vectors++;
      if (c_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL calc_ready: got %b want 1", c_ready);
      end
      tick();
      c_valid = 1'b0;
      vectors++;
      if ({ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data} !== {1'b0, 1'b1, 5'd5, 16'h00A0}) begin
         miscompares++;
         $display("[TB] FAIL calc37_strobe: got %h want %h",
                  {ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data}, {1'b0, 1'b1, 5'd5, 16'h00A0});
      end
      expMap[37] = 1'b1;
      tick();
      vectors++;
      if (loaded_map !== expMap) begin
         miscompares++;
         $display("[TB] FAIL calc37_map: got %h want %h", loaded_map, expMap);
      end
      for (int i = 0; i < 8; i++) begin
         a = 6'($urandom_range(0, 63));
         d = 16'($urandom);
         c_valid = 1'b1; c_addr = a; c_data = d;
         #1;
         vectors++;
         if (c_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL calc_rand_ready[%0d]: got %b want 1", i, c_ready);
         end
         tick();
         c_valid = 1'b0;
         clr_map = (i == 4);
         vectors++;
         if ({ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data} !== strobeOf(a, d)) begin
            miscompares++;
            $display("[TB] FAIL calc_rand_strobe[%0d]: got %h want %h", i,
                     {ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data}, strobeOf(a, d));
         end
         if (i == 4) expMap = '0;
         expMap[a] = 1'b1;
         tick();
         clr_map = 1'b0;
         vectors++;
         if (loaded_map !== expMap) begin
            miscompares++;
            $display("[TB] FAIL calc_rand_map[%0d]: got %h want %h", i, loaded_map, expMap);
         end
      end
   endtask

   // In IDLE the host wins; a word without sop is swallowed without a write.
   task automatic test_host_priority();
      logic        hv, cv;
      logic [5:0]  ca;
      logic [15:0] cd;
      for (int i = 0; i < 20; i++) begin
         hv = 1'($urandom_range(0, 1));
         cv = 1'($urandom_range(0, 1));
         ca = 6'($urandom_range(0, 63));
         cd = 16'($urandom);
         h_valid = hv; h_sop = 1'b0; h_eop = 1'($urandom_range(0, 1));
         h_addr = 6'($urandom_range(0, 63)); h_data = 16'($urandom);
         c_valid = cv; c_addr = ca; c_data = cd;
         #1;
         vectors++;
         if ({h_ready, c_ready} !== {1'b1, !hv}) begin
            miscompares++;
            $display("[TB] FAIL prio_ready[%0d]: got %b want %b", i, {h_ready, c_ready}, {1'b1, !hv});
         end
         tick();
         quiet();
         vectors++;
         if (!hv && cv) begin
            expMap[ca] = 1'b1;
            if ({ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data} !== strobeOf(ca, cd)) begin
               miscompares++;
               $display("[TB] FAIL prio_strobe[%0d]: got %h want %h", i,
                        {ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data}, strobeOf(ca, cd));
            end
         end else if ({ram_we_lo, ram_we_hi, arb_busy} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL prio_nowrite[%0d]: got we/busy %b want 000", i,
                     {ram_we_lo, ram_we_hi, arb_busy});
         end
      end
      tick();
      vectors++;
      if (loaded_map !== expMap) begin
         miscompares++;
         $display("[TB] FAIL prio_map: got %h want %h", loaded_map, expMap);
      end
   endtask

   // Calc held pending through a 36-word burst: one calc slot after every FairLimit host words.
   task automatic test_fair();
      int          k, win, strobes;
      logic [5:0]  ca, ha;
      logic [15:0] cd, hd;
      bit          fairSlot;
      logic [22:0] expW;
      k = 0; win = 0; strobes = 0;
      ca = 6'($urandom_range(0, 63)); cd = 16'($urandom);
      ha = 6'($urandom_range(0, 63)); hd = 16'($urandom);
      for (int cyc = 0; cyc < 100 && k < 36; cyc++) begin
         h_valid = 1'b1; h_sop = (k == 0); h_eop = (k == 35); h_addr = ha; h_data = hd;
         c_valid = 1'b1; c_addr = ca; c_data = cd;
         fairSlot = (win == FairLimit);
         #1;
         vectors++;
         if ({h_ready, c_ready} !== {!fairSlot, fairSlot}) begin
            miscompares++;
            $display("[TB] FAIL fair_ready[word %0d]: got %b want %b", k,
                     {h_ready, c_ready}, {!fairSlot, fairSlot});
         end
         expW = fairSlot ? strobeOf(ca, cd) : strobeOf(ha, swapB(hd));
         tick();
         if (ram_we_lo || ram_we_hi) strobes++;
         vectors++;
         if ({ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data} !== expW) begin
            miscompares++;
            $display("[TB] FAIL fair_strobe[word %0d]: got %h want %h", k,
                     {ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data}, expW);
         end
         if (fairSlot) begin
            expMap[ca] = 1'b1;
            win = 0;
            ca = 6'($urandom_range(0, 63)); cd = 16'($urandom);
         end else begin
            expMap[ha] = 1'b1;
            k++; win++;
            ha = 6'($urandom_range(0, 63)); hd = 16'($urandom);
         end
      end
      quiet();
      tick();
      expFrames++;
      vectors++;
      if ({frame_cnt, 32'(strobes)} !== {16'(expFrames), 32'd40}) begin
         miscompares++;
         $display("[TB] FAIL fair_totals: got frames=%0d strobes=%0d want frames=%0d strobes=40",
                  frame_cnt, strobes, expFrames);
      end
      tick();
      vectors++;
      if (loaded_map !== expMap) begin
         miscompares++;
         $display("[TB] FAIL fair_map: got %h want %h", loaded_map, expMap);
      end
   endtask

   // Stalled burst: idle count restarts on a word, then aborts after HostTimeout idle cycles.
   task automatic test_timeout();
      logic [5:0]  ha, ca;
      logic [15:0] hd, cd;
      ha = 6'($urandom_range(0, 63)); hd = 16'($urandom);
      h_valid = 1'b1; h_sop = 1'b1; h_addr = ha; h_data = hd;
      tick();
      quiet();
      vectors++;
      if ({ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data} !== strobeOf(ha, swapB(hd))) begin
         miscompares++;
         $display("[TB] FAIL to_sop_strobe: got %h want %h",
                  {ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data}, strobeOf(ha, swapB(hd)));
      end
      expMap[ha] = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         vectors++;
         if ({timeout_err, arb_busy} !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL to_early[%0d]: got %b want 01", k, {timeout_err, arb_busy});
         end
      end
      ha = 6'($urandom_range(0, 63)); hd = 16'($urandom);
      h_valid = 1'b1; h_addr = ha; h_data = hd;
      tick();
      quiet();
      vectors++;
      if ({ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data} !== strobeOf(ha, swapB(hd))) begin
         miscompares++;
         $display("[TB] FAIL to_mid_strobe: got %h want %h",
                  {ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data}, strobeOf(ha, swapB(hd)));
      end
      expMap[ha] = 1'b1;
      for (int k = 1; k <= HostTimeout; k++) begin
         tick();
         vectors++;
         if ({timeout_err, arb_busy} !== {(k == HostTimeout), (k < HostTimeout)}) begin
            miscompares++;
            $display("[TB] FAIL to_count[%0d]: got %b want %b", k, {timeout_err, arb_busy},
                     {(k == HostTimeout), (k < HostTimeout)});
         end
      end
      tick();
      vectors++;
      if ({timeout_err, frame_cnt} !== {1'b0, 16'(expFrames)}) begin
         miscompares++;
         $display("[TB] FAIL to_after: got err=%b frames=%0d want err=0 frames=%0d",
                  timeout_err, frame_cnt, expFrames);
      end
      ca = 6'($urandom_range(0, 63)); cd = 16'($urandom);
      c_valid = 1'b1; c_addr = ca; c_data = cd;
      #1;
      vectors++;
      if (c_ready !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL to_calc_ready: got %b want 1", c_ready);
      end
      tick();
      quiet();
      vectors++;
      if ({ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data} !== strobeOf(ca, cd)) begin
         miscompares++;
         $display("[TB] FAIL to_calc_strobe: got %h want %h",
                  {ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data}, strobeOf(ca, cd));
      end
      expMap[ca] = 1'b1;
      tick();
      vectors++;
      if (loaded_map !== expMap) begin
         miscompares++;
         $display("[TB] FAIL to_map: got %h want %h", loaded_map, expMap);
      end
   endtask

   // Freeze blocks every calc grant.
   task automatic test_freeze();
      cal_freeze = 1'b1;
      for (int i = 0; i < 100; i++) begin
         c_valid = 1'b1; c_addr = 6'($urandom_range(0, 63)); c_data = 16'($urandom);
         #1;
         vectors++;
         if (c_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL freeze_ready[%0d]: got %b want 0", i, c_ready);
         end
         tick();
         vectors++;
         if ({ram_we_lo, ram_we_hi} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL freeze_we[%0d]: got %b want 00", i, {ram_we_lo, ram_we_hi});
         end
      end
      quiet();
      cal_freeze = 1'b0;
   endtask

   // Reset lands while host word 10 is presented: nothing of it survives.
   task automatic test_reset_mid_burst();
      for (int n = 0; n < 10; n++) begin
         h_valid = 1'b1; h_sop = (n == 0); h_eop = 1'b0;
         h_addr = 6'($urandom_range(0, 63)); h_data = 16'($urandom);
         tick();
      end
      h_valid = 1'b1; h_sop = 1'b0; h_addr = 6'($urandom_range(0, 63)); h_data = 16'($urandom);
      #1;
      reset = 1'b1;
      #1;
      vectors++;
      if ({h_ready, c_ready, ram_we_lo, ram_we_hi, ram_wr_addr, ram_wr_data, loaded_map,
           arb_busy, frame_cnt, timeout_err} !== '0) begin
         miscompares++;
         $display("[TB] FAIL midrst_now: got rdy=%b%b we=%b%b map=%h busy=%b fc=%0d want all 0",
                  h_ready, c_ready, ram_we_lo, ram_we_hi, loaded_map, arb_busy, frame_cnt);
      end
      tick();
      vectors++;
      if ({ram_we_lo, ram_we_hi, loaded_map, all_loaded} !== '0) begin
         miscompares++;
         $display("[TB] FAIL midrst_edge: got we=%b%b map=%h al=%b want all 0",
                  ram_we_lo, ram_we_hi, loaded_map, all_loaded);
      end
      quiet();
      reset = 1'b0;
      expMap = '0;
      expFrames = 0;
      tick();
      vectors++;
      if ({h_ready, arb_busy, frame_cnt, loaded_map} !== {1'b1, 1'b0, 16'(expFrames), expMap}) begin
         miscompares++;
         $display("[TB] FAIL midrst_after: got rdy=%b busy=%b fc=%0d map=%h want 1 0 0 0",
                  h_ready, arb_busy, frame_cnt, loaded_map);
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_full_frame();
      test_calc_only();
      test_host_priority();
      test_fair();
      test_timeout();
      test_freeze();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
